// File: rtl/char_scanout.sv
// Character-buffer scanout: walks one character row per scanline, fetches font rows
// and serialises them into a gap-free 1-bit pixel stream with scroll and blinking cursor.
module char_scanout #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 24,
    parameter int unsigned ADDR_BITS    = 11,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 line_req,
    input  logic [4:0]           first_row,
    input  logic                 cursor_en,
    input  logic [6:0]           cursor_col,
    input  logic [4:0]           cursor_row,
    output logic [ADDR_BITS-1:0] raddr,
    input  logic [7:0]           rdata,
    output logic [10:0]          font_addr,
    input  logic [7:0]           font_data,
    output logic                 pixel,
    output logic                 pixel_valid,
    output logic                 line_done,
    output logic                 busy
);

    localparam int unsigned LINE_END = 8 * COLS + 4;
    localparam int unsigned KW       = $clog2(LINE_END + 1);
    localparam int unsigned BW       = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned AW1      = ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, LINE, FRAME_DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [7:0]            sr_q, sr_d;
    logic [4:0]            screen_row_q, screen_row_d;
    logic [3:0]            scanline_q, scanline_d;
    logic [ADDR_BITS-1:0]  row_base_q, row_base_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [ADDR_BITS-1:0]  raddr_d;
    logic [10:0]           font_addr_d;
    logic                  pixel_valid_d, line_done_d, busy_d;

    logic [KW-1:0]         kn_c;
    logic [6:0]            col_c;
    logic                  cursor_hit_c;
    logic [4:0]            fr_mod_c;
    logic [AW1-1:0]        next_base_c;
    logic [BW-1:0]         blink_inc_c;
    logic                  rdata_msb_unused;

    assign rdata_msb_unused = rdata[7];
    assign pixel            = sr_q[7];

    // Constant-coefficient shift-add: buffer row index to its start address
    function automatic logic [ADDR_BITS-1:0] row_to_base(input logic [4:0] r);
        logic [ADDR_BITS-1:0] acc;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            if (r[i]) acc = acc + ADDR_BITS'(COLS << i);
        end
        return acc;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            sr_q          <= '0;
            screen_row_q  <= '0;
            scanline_q    <= '0;
            row_base_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            raddr         <= '0;
            font_addr     <= '0;
            pixel_valid   <= 1'b0;
            line_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            sr_q          <= sr_d;
            screen_row_q  <= screen_row_d;
            scanline_q    <= scanline_d;
            row_base_q    <= row_base_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            raddr         <= raddr_d;
            font_addr     <= font_addr_d;
            pixel_valid   <= pixel_valid_d;
            line_done     <= line_done_d;
            busy          <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        sr_d          = sr_q;
        screen_row_d  = screen_row_q;
        scanline_d    = scanline_q;
        row_base_d    = row_base_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        raddr_d       = raddr;
        font_addr_d   = font_addr;
        pixel_valid_d = pixel_valid;
        line_done_d   = 1'b0;
        busy_d        = busy;

        // kn_c is the edge index (since line start) that this cycle's update lands on
        kn_c         = k_q + KW'(1);
        col_c        = 7'(kn_c >> 3);
        cursor_hit_c = cursor_en && blink_phase_q &&
                       (screen_row_q == cursor_row) && (col_c == cursor_col);
        fr_mod_c     = (first_row >= 5'(ROWS)) ? first_row - 5'(ROWS) : first_row;
        next_base_c  = {1'b0, row_base_q} + AW1'(COLS);
        if (next_base_c >= AW1'(ROWS * COLS)) next_base_c = next_base_c - AW1'(ROWS * COLS);
        blink_inc_c  = blink_cnt_q + BW'(1);

        if (frame_start) begin
            state_d       = IDLE;
            sr_d          = '0;
            pixel_valid_d = 1'b0;
            busy_d        = 1'b0;
            screen_row_d  = '0;
            scanline_d    = '0;
            row_base_d    = row_to_base(fr_mod_c);
            if (blink_inc_c == BW'(BLINK_FRAMES)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_inc_c;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_req) begin
                        state_d = LINE;
                        k_d     = '0;
                        raddr_d = row_base_q;
                        busy_d  = 1'b1;
                    end
                end
                LINE: begin
                    k_d = kn_c;
                    if (kn_c[2:0] == 3'd0 && kn_c < KW'(8 * COLS))
                        raddr_d = raddr + ADDR_BITS'(1);
                    if (kn_c[2:0] == 3'd2 && kn_c < KW'(8 * COLS))
                        font_addr_d = {rdata[6:0], scanline_q};
                    if (kn_c == KW'(LINE_END)) begin
                        pixel_valid_d = 1'b0;
                        line_done_d   = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = IDLE;
                        if (scanline_q == 4'd15) begin
                            scanline_d = '0;
                            if (screen_row_q == 5'(ROWS - 1)) begin
                                state_d = FRAME_DONE;
                            end else begin
                                screen_row_d = screen_row_q + 5'd1;
                                row_base_d   = ADDR_BITS'(next_base_c);
                            end
                        end else begin
                            scanline_d = scanline_q + 4'd1;
                        end
                    end else if (kn_c[2:0] == 3'd4) begin
                        sr_d          = font_data ^ {8{cursor_hit_c}};
                        pixel_valid_d = 1'b1;
                    end else begin
                        sr_d = {sr_q[6:0], 1'b0};
                    end
                end
                FRAME_DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_scanout.sv
// Self-checking bench for char_scanout: random buffer/font contents against a
// frame-level pixel model (scroll, scanline stepping, cursor blink, abort, reset).
module tb_char_scanout;

    localparam int COLS     = 10;
    localparam int ROWS     = 24;
    localparam int ABITS    = 11;
    localparam int BLINK    = 2;
    localparam int LINE_END = 8 * COLS + 4;
    localparam int BUDGET   = LINE_END + 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             frame_start;
    logic             line_req;
    logic [4:0]       first_row;
    logic             cursor_en;
    logic [6:0]       cursor_col;
    logic [4:0]       cursor_row;
    logic [ABITS-1:0] raddr;
    logic [7:0]       rdata;
    logic [10:0]      font_addr;
    logic [7:0]       font_data;
    logic             pixel;
    logic             pixel_valid;
    logic             line_done;
    logic             busy;

    logic [7:0] mem  [0:2047];
    logic [7:0] font [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_fr, m_line, m_frames;

    // capture results of one scanline
    bit          cap_pix[$];
    int          cap_first, cap_done_cnt, cap_done_j, cap_gaps;
    logic [10:0] cap_raddr0, cap_raddr_last, cap_fa2;
    logic        cap_busy0, cap_busy_end;

    always #5 clk = ~clk;

    char_scanout #(.COLS(COLS), .ROWS(ROWS), .ADDR_BITS(ABITS), .BLINK_FRAMES(BLINK)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .line_req(line_req),
        .first_row(first_row), .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .raddr(raddr), .rdata(rdata), .font_addr(font_addr),
        .font_data(font_data), .pixel(pixel), .pixel_valid(pixel_valid),
        .line_done(line_done), .busy(busy)
    );

    // synchronous buffer and font ROM, one cycle of read latency each
    always @(posedge clk) begin
        rdata     <= mem[raddr];
        font_data <= font[font_addr];
    end

    function automatic bit vis();
        return ((m_frames / BLINK) % 2) == 0;
    endfunction

    function automatic int exp_base();
        return ((m_fr + m_line / 16) % ROWS) * COLS;
    endfunction

    function automatic bit exp_pix(input int p);
        int col, srow, sl, a;
        logic [7:0] ch, f;
        bit inv;
        col  = p / 8;
        srow = m_line / 16;
        sl   = m_line % 16;
        a    = ((m_fr + srow) % ROWS) * COLS + col;
        ch   = mem[a] & 8'h7f;
        f    = font[int'(ch) * 16 + sl];
        inv  = cursor_en && vis() && (srow == int'(cursor_row)) && (col == int'(cursor_col));
        return f[7 - p % 8] ^ inv;
    endfunction

    function automatic int stream_errors();
        int e = 0;
        for (int p = 0; p < cap_pix.size(); p++)
            if (cap_pix[p] !== exp_pix(p)) e++;
        return e;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) begin
            mem[i]  = 8'($urandom);
            font[i] = 8'($urandom);
        end
    endtask

    task automatic fill_font(input logic [7:0] v);
        for (int i = 0; i < 2048; i++) font[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_fr = 0; m_line = 0; m_frames = 0;
    endtask

    task automatic do_frame_start(input int fr);
        @(negedge clk);
        first_row   = 5'(fr);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        m_fr     = (fr >= ROWS) ? fr - ROWS : fr;
        m_line   = 0;
        m_frames = m_frames + 1;
    endtask

    // issue line_req and record outputs for a bounded number of cycles
    task automatic capture_line(input int budget, input int abort_j);
        bit prev_v;
        prev_v = 1'b0;
        cap_pix.delete();
        cap_first = -1; cap_done_cnt = 0; cap_done_j = -1; cap_gaps = 0;
        @(negedge clk);
        line_req = 1'b1;
        for (int j = 0; j < budget; j++) begin
            @(negedge clk);
            if (j == 0) begin
                line_req   = 1'b0;
                cap_raddr0 = raddr;
                cap_busy0  = busy;
            end
            if (j == 2) cap_fa2 = font_addr;
            if (j == 8 * (COLS - 1)) cap_raddr_last = raddr;
            if (pixel_valid === 1'b1) begin
                if (cap_first < 0) cap_first = j;
                else if (!prev_v) cap_gaps++;
                cap_pix.push_back(pixel);
            end
            prev_v = (pixel_valid === 1'b1);
            if (line_done === 1'b1) begin
                cap_done_cnt++;
                if (cap_done_j < 0) cap_done_j = j;
            end
            if (j == abort_j) frame_start = 1'b1;
            else if (j == abort_j + 1) frame_start = 1'b0;
        end
        cap_busy_end = busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if ({raddr, font_addr, pixel, pixel_valid, line_done, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got raddr=%0h fa=%0h pix=%b pv=%b ld=%b busy=%b want all 0",
                     raddr, font_addr, pixel, pixel_valid, line_done, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_fr = 0; m_line = 0; m_frames = 0;
    endtask

    task automatic test_first_char();
        int e;
        fill_random();
        fill_font(8'hA5);
        mem[0] = 8'h41;
        do_frame_start(0);
        capture_line(BUDGET, -1);
        n_cmp++;
        if (cap_raddr0 !== 11'd0) begin
            n_bad++; $display("FAIL first_raddr: got %0d want 0", cap_raddr0);
        end
        n_cmp++;
        if (cap_fa2 !== 11'h410) begin
            n_bad++; $display("FAIL first_font_addr: got %0h want 410", cap_fa2);
        end
        n_cmp++;
        if (cap_first != 4) begin
            n_bad++; $display("FAIL first_valid_cycle: got %0d want 4", cap_first);
        end
        n_cmp++;
        if (cap_pix.size() != 8 * COLS || cap_gaps != 0) begin
            n_bad++; $display("FAIL valid_count: got %0d (gaps %0d) want %0d", cap_pix.size(), cap_gaps, 8 * COLS);
        end
        n_cmp++;
        if (cap_pix.size() < 8 || {cap_pix[0], cap_pix[1], cap_pix[2], cap_pix[3],
                                   cap_pix[4], cap_pix[5], cap_pix[6], cap_pix[7]} !== 8'b10100101) begin
            n_bad++; $display("FAIL first_pixels: want 10100101, captured %0d pixels", cap_pix.size());
        end
        e = stream_errors();
        n_cmp++;
        if (e != 0) begin
            n_bad++; $display("FAIL first_stream: got %0d wrong pixels want 0", e);
        end
        n_cmp++;
        if (cap_done_j != LINE_END || cap_done_cnt != 1 || cap_busy0 !== 1'b1 || cap_busy_end !== 1'b0) begin
            n_bad++; $display("FAIL first_line_done: got at %0d x%0d busy %b/%b want at %0d x1 busy 1/0",
                              cap_done_j, cap_done_cnt, cap_busy0, cap_busy_end, LINE_END);
        end
        m_line++;
    endtask

    task automatic test_full_frame();
        int e;
        fill_random();
        cursor_en  = 1'b1;
        cursor_row = 5'($urandom_range(ROWS - 1));
        do_frame_start(0);
        for (int l = 0; l < ROWS * 16; l++) begin
            cursor_col = 7'($urandom_range(COLS - 1));
            if (l % 16 == 0) cursor_row = (l == 0 || $urandom_range(1) == 0) ? 5'(l / 16) : 5'($urandom_range(ROWS - 1));
            capture_line(BUDGET, -1);
            e = stream_errors();
            n_cmp++;
            if (e != 0 || cap_pix.size() != 8 * COLS || cap_gaps != 0) begin
                n_bad++; $display("FAIL frame_stream line %0d: got %0d wrong of %0d want 0 of %0d", l, e, cap_pix.size(), 8 * COLS);
            end
            n_cmp++;
            if (int'(cap_raddr0) != exp_base() || int'(cap_raddr_last) != exp_base() + COLS - 1) begin
                n_bad++; $display("FAIL frame_raddr line %0d: got %0d..%0d want %0d..%0d",
                                  l, cap_raddr0, cap_raddr_last, exp_base(), exp_base() + COLS - 1);
            end
            n_cmp++;
            if (int'(cap_fa2[3:0]) != l % 16 || cap_done_j != LINE_END || cap_done_cnt != 1) begin
                n_bad++; $display("FAIL frame_scanline line %0d: got nibble %0d done@%0d want nibble %0d done@%0d",
                                  l, cap_fa2[3:0], cap_done_j, l % 16, LINE_END);
            end
            m_line++;
        end
        capture_line(20, -1);
        n_cmp++;
        if (cap_first != -1 || cap_busy0 !== 1'b0 || cap_done_cnt != 0) begin
            n_bad++; $display("FAIL frame_done_ignore: got first_valid %0d busy %b want -1 busy 0", cap_first, cap_busy0);
        end
    endtask

    task automatic test_scroll();
        int e;
        fill_random();
        cursor_en = 1'b0;
        do_frame_start(23);
        for (int l = 0; l < 17; l++) begin
            capture_line(BUDGET, -1);
            e = stream_errors();
            n_cmp++;
            if (e != 0 || cap_pix.size() != 8 * COLS) begin
                n_bad++; $display("FAIL scroll_stream line %0d: got %0d wrong want 0", l, e);
            end
            if (l == 0) begin
                n_cmp++;
                if (cap_raddr0 !== 11'(23 * COLS) || cap_raddr_last !== 11'(24 * COLS - 1)) begin
                    n_bad++; $display("FAIL scroll_row23: got %0d..%0d want %0d..%0d",
                                      cap_raddr0, cap_raddr_last, 23 * COLS, 24 * COLS - 1);
                end
            end
            if (l == 16) begin
                n_cmp++;
                if (cap_raddr0 !== 11'd0 || cap_fa2[3:0] !== 4'd0) begin
                    n_bad++; $display("FAIL scroll_wrap: got raddr %0d nibble %0d want 0 0", cap_raddr0, cap_fa2[3:0]);
                end
            end
            m_line++;
        end
        do_frame_start(29);
        capture_line(BUDGET, -1);
        n_cmp++;
        if (cap_raddr0 !== 11'(5 * COLS) || stream_errors() != 0) begin
            n_bad++; $display("FAIL scroll_oob_first_row: got raddr %0d want %0d", cap_raddr0, 5 * COLS);
        end
        m_line++;
    endtask

    task automatic check_cursor_cell(input string name, input bit lit);
        int bad;
        bad = 0;
        for (int p = 0; p < cap_pix.size(); p++)
            if (cap_pix[p] !== ((lit && p >= 40 && p < 48) ? 1'b1 : 1'b0)) bad++;
        n_cmp++;
        if (bad != 0 || cap_pix.size() != 8 * COLS) begin
            n_bad++; $display("FAIL %s: got %0d wrong of %0d pixels want 0 wrong (cell lit=%0d)", name, bad, cap_pix.size(), lit);
        end
        m_line++;
    endtask

    task automatic test_cursor();
        fill_random();
        fill_font(8'h00);
        do_reset();
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd0;
        do_frame_start(0);
        capture_line(BUDGET, -1);
        check_cursor_cell("cursor_on", 1'b1);
        do_frame_start(0);
        do_frame_start(0);
        capture_line(BUDGET, -1);
        check_cursor_cell("cursor_blink_off", 1'b0);
        do_frame_start(0);
        do_frame_start(0);
        capture_line(BUDGET, -1);
        check_cursor_cell("cursor_blink_on", 1'b1);
        cursor_col = 7'd100;
        capture_line(BUDGET, -1);
        check_cursor_cell("cursor_oob_col", 1'b0);
        cursor_col = 7'd5;
    endtask

    task automatic test_abort();
        int e;
        fill_random();
        do_frame_start(0);
        for (int l = 0; l < 3; l++) begin
            capture_line(BUDGET, -1);
            m_line++;
        end
        capture_line(BUDGET, 4 + 50);
        e = stream_errors();
        n_cmp++;
        if (cap_pix.size() != 51 || cap_done_cnt != 0 || e != 0 || cap_busy_end !== 1'b0) begin
            n_bad++; $display("FAIL abort_midline: got %0d pixels %0d done %0d wrong busy %b want 51 0 0 0",
                              cap_pix.size(), cap_done_cnt, e, cap_busy_end);
        end
        m_fr = int'(first_row); m_line = 0; m_frames++;
        capture_line(BUDGET, -1);
        n_cmp++;
        if (int'(cap_raddr0) != exp_base() || cap_fa2[3:0] !== 4'd0 || stream_errors() != 0) begin
            n_bad++; $display("FAIL abort_restart: got raddr %0d nibble %0d want %0d 0", cap_raddr0, cap_fa2[3:0], exp_base());
        end
        m_line++;
    endtask

    task automatic test_back_to_back();
        int act;
        capture_line(BUDGET, -1);
        m_line++;
        @(negedge clk);
        frame_start = 1'b1; line_req = 1'b1; first_row = 5'd2;
        @(negedge clk);
        frame_start = 1'b0; line_req = 1'b0;
        m_fr = 2; m_line = 0; m_frames++;
        act = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (busy !== 1'b0 || pixel_valid !== 1'b0) act++;
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++; $display("FAIL simultaneous_fs_lr: got %0d active cycles want 0", act);
        end
        capture_line(BUDGET, -1);
        n_cmp++;
        if (cap_raddr0 !== 11'(2 * COLS) || cap_fa2[3:0] !== 4'd0 || stream_errors() != 0) begin
            n_bad++; $display("FAIL simultaneous_next_line: got raddr %0d nibble %0d want %0d 0", cap_raddr0, cap_fa2[3:0], 2 * COLS);
        end
        m_line++;
    endtask

    task automatic test_async_reset();
        while (vis()) do_frame_start(0);
        @(negedge clk);
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || pixel_valid !== 1'b1) begin
            n_bad++; $display("FAIL async_reset_precond: got busy %b pv %b want 1 1", busy, pixel_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({raddr, font_addr, pixel, pixel_valid, line_done, busy} !== '0) begin
            n_bad++; $display("FAIL async_reset: got raddr=%0h fa=%0h pix=%b pv=%b ld=%b busy=%b want all 0",
                              raddr, font_addr, pixel, pixel_valid, line_done, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_fr = 0; m_line = 0; m_frames = 0;
        fill_font(8'h00);
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd0;
        do_frame_start(0);
        capture_line(BUDGET, -1);
        check_cursor_cell("reset_blink_phase", 1'b1);
    endtask

    initial begin
        frame_start = 1'b0; line_req = 1'b0; first_row = 5'd0;
        cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
        fill_random();
        test_reset();
        test_first_char();
        test_full_frame();
        test_scroll();
        test_cursor();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/char_scanout.md
Name: char_scanout

Overview:
- Display-side reader of the 80x24 character buffer.
- On each scanline request it walks one character row of the buffer in column order through the buffer's synchronous read port.
- It turns each character code into a font-ROM row address, then serialises the returned 8-pixel font row into a gap-free 1-bit pixel stream.
- It also applies hardware scroll (start-row offset) and a blinking inverse cursor. Sits between the character buffer and the video timing/output stage.

Parameters:
- COLS, 80, characters per row
- ROWS, 24, character rows per frame
- ADDR_BITS, 11, buffer read-address width
- BLINK_FRAMES, 30, frames per cursor blink half-period (must be >= 1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse: start of a new frame; restarts the row/scanline position
- line_req  in  1  one-cycle pulse: emit the next scanline
- first_row  in  5  buffer row shown at screen row 0 (0..ROWS-1); sampled on frame_start
- cursor_en  in  1  cursor display enable
- cursor_col  in  7  cursor screen column (0..COLS-1)
- cursor_row  in  5  cursor screen row (0..ROWS-1)
- raddr  out  ADDR_BITS  registered read address to the char buffer; buffer returns data 1 cycle later
- rdata  in  8  char buffer read data
- font_addr  out  11  registered font-ROM address {rdata[6:0], scanline[3:0]}; ROM returns data 1 cycle later
- font_data  in  8  font row; bit 7 is the leftmost pixel
- pixel  out  1  pixel value (1 = lit)
- pixel_valid  out  1  pixel qualifier
- line_done  out  1  one-cycle pulse after the last pixel of a scanline
- busy  out  1  high while a scanline is in progress

Behaviour:
- Reset (asynchronous):
  - raddr, font_addr, pixel, pixel_valid, line_done, busy all 0.
  - State IDLE; screen_row 0, scanline 0; latched first_row 0.
  - Blink counter 0, blink phase 1 (visible).
- State machine has three states: IDLE, LINE, FRAME_DONE.
- IDLE:
  - line_req -> LINE, busy=1.
  - On the edge that samples line_req, raddr <= base + 0.
  - base = ((first_row_latched + screen_row) mod ROWS) * COLS.
  - base is computed incrementally with a compare-subtract wrap; no multiplier.
- LINE pipeline, character n:
  - raddr for char n is issued at edge E0+8n.
  - font_addr is registered at E0+8n+2.
  - The shift register loads font_data at E0+8n+4.
  - pixel_valid is high from E0+4 through E0+4+8*COLS-1: exactly 8*COLS consecutive cycles, no gaps. pixel = MSB first.
  - rdata[7] is ignored.
- Cursor:
  - Applies when cursor_en=1, blink phase=1, screen_row==cursor_row and column==cursor_col.
  - All 8 pixels of that cell are inverted on every scanline of the row.
- End of scanline:
  - The edge after the last valid pixel sets pixel_valid=0, line_done=1 for 1 cycle, busy=0.
  - scanline increments. At 15 it wraps to 0 and screen_row increments.
  - When screen_row would reach ROWS -> FRAME_DONE; otherwise -> IDLE.
- FRAME_DONE: line_req is ignored.
- frame_start (any state, highest priority):
  - Aborts any scanline in progress: pixel_valid=0, no line_done.
  - screen_row=0, scanline=0; latches first_row -> IDLE.
  - Increments the blink counter. On reaching BLINK_FRAMES: counter=0, phase toggles.
- Simultaneous frame_start and line_req: frame_start wins; line_req is dropped.
- line_req while busy: ignored.
- first_row >= ROWS: treated as first_row mod ROWS via a single subtract. Out-of-range cursor coordinates simply never match.
- raddr never exceeds ROWS*COLS-1; wrap from buffer row ROWS-1 goes to row 0.

Test Plan:
- Reset, preload buffer with 'A'(0x41) at addr 0, font ROM returning 0xA5; frame_start, line_req -> raddr=0 at E0; font_addr=0x410 at E0+2; pixel_valid first high at E0+4; first 8 pixels 1,0,1,0,0,1,0,1; 640 valid cycles then a line_done pulse.
- Issue 16 line_req -> font_addr low nibble steps 0..15. The 17th line uses raddr 80..159 with scanline 0. After 384 lines state is FRAME_DONE and a further line_req gives no pixel_valid.
- first_row=23 latched at frame_start -> screen row 0 reads raddr 1840..1919. After 16 lines, screen row 1 reads raddr 0.
- cursor_en=1, cursor (col 5, row 0), blank font 0x00 -> pixels 40..47 of scanline 0 read 1, all others 0. After BLINK_FRAMES=2 frame_starts the same cell reads 0; after 2 more it reads 1 again.
- frame_start asserted mid-line at pixel 100 -> pixel_valid drops next edge, no line_done, next line_req restarts at raddr 0 scanline 0. frame_start and line_req in the same cycle -> no scanline started.
- Assert reset_n low mid-line -> all outputs 0 immediately (asynchronous). Blink phase is 1 after release.
